// File: rtl/dmem_access_unit.sv
// dmem_access_unit: data-memory stage with a byte-addressed local RAM.
// Supports byte/half/word stores and loads, sign/zero extension on loads,
// a READ_LAT-cycle read with a stall handshake back to the core, and
// detection of misaligned, illegal or conflicting requests.
// Optional macro DMEM_STATS_EN adds saturating 16-bit rd/wr/err counters.
module dmem_access_unit #(
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic              rd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              stall,
    output logic              access_err
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count,
    output logic [15:0]       err_count
`endif
);

    localparam int WORD_AW = ADDR_W - 2;
    localparam int WORDS   = 2 ** WORD_AW;

    typedef enum logic [0:0] {IDLE, RD_WAIT} state_t;

    state_t              state_reg, state_next;
    logic [2:0]          cnt_reg, cnt_next;
    logic [ADDR_W-1:0]   req_addr_reg;
    logic [2:0]          req_funct3_reg;
    logic                req_bad_reg;
    logic [DATA_W-1:0]   rd_hold_reg;

    logic                wr_req, rd_req, conflict, store_bad, wr_commit;
    logic [3:0]          byte_en;
    logic [DATA_W-1:0]   lane_data;
    logic [WORD_AW-1:0]  ram_word_addr;
    logic [DATA_W-1:0]   ram_q;
    logic [DATA_W-1:0]   load_data;
    logic [1:0]          req_off;

    // True when funct3/alignment make the access unusable; the unsigned
    // load codes are not valid for stores.
    function automatic logic access_bad(input logic [2:0] f3,
                                        input logic [1:0] off,
                                        input logic       is_store);
        case (f3)
            3'b000:  access_bad = 1'b0;
            3'b001:  access_bad = off[0];
            3'b010:  access_bad = |off;
            3'b100:  access_bad = is_store;
            3'b101:  access_bad = is_store | off[0];
            default: access_bad = 1'b1;
        endcase
    endfunction

    // Request decode; nothing is accepted while reset is held.
    assign wr_req    = reset && (state_reg == IDLE) && wr && !rd;
    assign rd_req    = reset && (state_reg == IDLE) && rd && !wr;
    assign conflict  = reset && (state_reg == IDLE) && wr && rd;
    assign store_bad = access_bad(funct3, addr[1:0], 1'b1);
    assign wr_commit = wr_req && !store_bad;

    // FSM next state, latency countdown, stall and rd_valid.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        stall      = 1'b0;
        rd_valid   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (rd_req) begin
                    stall      = 1'b1;
                    state_next = RD_WAIT;
                    cnt_next   = 3'(READ_LAT - 1);
                end
            end
            RD_WAIT: begin
                if (cnt_reg != 3'd0) begin
                    stall    = 1'b1;
                    cnt_next = cnt_reg - 3'd1;
                end else begin
                    rd_valid   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, counter, latched read request and held load result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= 3'd0;
            req_addr_reg   <= '0;
            req_funct3_reg <= 3'd0;
            req_bad_reg    <= 1'b0;
            rd_hold_reg    <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (rd_req) begin
                req_addr_reg   <= addr;
                req_funct3_reg <= funct3;
                req_bad_reg    <= access_bad(funct3, addr[1:0], 1'b0);
            end
            if (rd_valid) begin
                rd_hold_reg <= load_data;
            end
        end
    end

    // Store lane steering: replicate the right-aligned data to every lane
    // and let the byte enables pick the target bytes.
    always_comb begin
        byte_en   = 4'b0000;
        lane_data = wr_data;
        case (funct3[1:0])
            2'b00: begin
                byte_en   = 4'b0001 << addr[1:0];
                lane_data = {4{wr_data[7:0]}};
            end
            2'b01: begin
                byte_en   = 4'b0011 << addr[1:0];
                lane_data = {2{wr_data[15:0]}};
            end
            default: begin
                byte_en   = 4'b1111;
                lane_data = wr_data;
            end
        endcase
        if (!wr_commit) begin
            byte_en = 4'b0000;
        end
    end

    // While idle the RAM follows the live address, so a 1-cycle latency
    // read has its word ready; during RD_WAIT it re-reads the latched word.
    assign ram_word_addr = (state_reg == IDLE) ? addr[ADDR_W-1:2]
                                               : req_addr_reg[ADDR_W-1:2];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bank
            logic [7:0] mem [WORDS];
            logic [7:0] bank_q;
            // One byte lane: write with byte enable, registered read.
            always_ff @(posedge clk) begin
                if (byte_en[gi]) begin
                    mem[ram_word_addr] <= lane_data[8*gi +: 8];
                end
                bank_q <= mem[ram_word_addr];
            end
            assign ram_q[8*gi +: 8] = bank_q;
        end
    endgenerate

    assign req_off = req_addr_reg[1:0];

    // Select and extend the loaded bytes; bad loads return zero.
    always_comb begin
        load_data = '0;
        case (req_funct3_reg)
            3'b000:  load_data = {{24{ram_q[{req_off, 3'b000} + 7]}},
                                  ram_q[{req_off, 3'b000} +: 8]};
            3'b001:  load_data = {{16{ram_q[{req_off[1], 4'b0000} + 15]}},
                                  ram_q[{req_off[1], 4'b0000} +: 16]};
            3'b010:  load_data = ram_q;
            3'b100:  load_data = {24'd0, ram_q[{req_off, 3'b000} +: 8]};
            3'b101:  load_data = {16'd0, ram_q[{req_off[1], 4'b0000} +: 16]};
            default: load_data = '0;
        endcase
        if (req_bad_reg) begin
            load_data = '0;
        end
    end

    assign rd_data    = rd_valid ? load_data : rd_hold_reg;
    assign access_err = conflict || (wr_req && store_bad) || (rd_valid && req_bad_reg);

`ifdef DMEM_STATS_EN
    logic [15:0] rd_count_reg, wr_count_reg, err_count_reg;

    // Saturating event counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_count_reg  <= 16'd0;
            wr_count_reg  <= 16'd0;
            err_count_reg <= 16'd0;
        end else begin
            if (rd_valid && rd_count_reg != 16'hFFFF) begin
                rd_count_reg <= rd_count_reg + 16'd1;
            end
            if (wr_commit && wr_count_reg != 16'hFFFF) begin
                wr_count_reg <= wr_count_reg + 16'd1;
            end
            if (access_err && err_count_reg != 16'hFFFF) begin
                err_count_reg <= err_count_reg + 16'd1;
            end
        end
    end

    assign rd_count  = rd_count_reg;
    assign wr_count  = wr_count_reg;
    assign err_count = err_count_reg;
`endif

endmodule

// File: tb/tb_dmem_access_unit.sv
// Testbench for dmem_access_unit: directed scenarios plus randomized
// traffic checked against a byte-array memory model.
module tb_dmem_access_unit;

    localparam int ADDR_W   = 9;
    localparam int READ_LAT = 2;
    localparam int DEPTH    = 2 ** ADDR_W;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              wr = 1'b0;
    logic              rd = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [2:0]        funct3 = 3'd0;
    logic [31:0]       wr_data = 32'd0;
    logic [31:0]       rd_data;
    logic              rd_valid;
    logic              stall;
    logic              access_err;
`ifdef DMEM_STATS_EN
    logic [15:0]       rd_count, wr_count, err_count;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0]  model_mem [DEPTH];
    int          exp_rd_cnt = 0;
    int          exp_wr_cnt = 0;
    int          exp_err_cnt = 0;
    logic [31:0] last_rd = 32'd0;

    dmem_access_unit #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (32),
        .READ_LAT (READ_LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr         (wr),
        .rd         (rd),
        .addr       (addr),
        .funct3     (funct3),
        .wr_data    (wr_data),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .stall      (stall),
        .access_err (access_err)
`ifdef DMEM_STATS_EN
        ,
        .rd_count   (rd_count),
        .wr_count   (wr_count),
        .err_count  (err_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic int acc_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit model_bad(input int a, input logic [2:0] f3, input bit st);
        case (f3)
            3'b000:  return 1'b0;
            3'b001:  return (a % 2) != 0;
            3'b010:  return (a % 4) != 0;
            3'b100:  return st;
            3'b101:  return st || ((a % 2) != 0);
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input int a, input logic [2:0] f3);
        logic [31:0] v = 32'd0;
        int n = acc_size(f3);
        for (int i = 0; i < n; i++) begin
            v = v | (32'(model_mem[(a + i) % DEPTH]) << (8 * i));
        end
        if (f3 == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
        if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic do_write(input int a, input logic [2:0] f3, input logic [31:0] d);
        bit bad = model_bad(a, f3, 1'b1);
        @(negedge clk);
        wr = 1'b1; rd = 1'b0; addr = a[ADDR_W-1:0]; funct3 = f3; wr_data = d;
        #1;
        checks++;
        if (access_err !== bad || stall !== 1'b0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL write_resp addr=%h f3=%b: err=%b stall=%b rd_valid=%b, expected err=%b stall=0 rd_valid=0",
                     a, f3, access_err, stall, rd_valid, bad);
        end
        @(posedge clk);
        if (!bad) begin
            for (int i = 0; i < acc_size(f3); i++) begin
                model_mem[(a + i) % DEPTH] = 8'(d >> (8 * i));
            end
            exp_wr_cnt++;
        end else begin
            exp_err_cnt++;
        end
        $display("WR   addr=%h f3=%b data=%h err=%b", a, f3, d, bad);
    endtask

    task automatic do_read(input int a, input logic [2:0] f3, input bit chk_data);
        bit          bad = model_bad(a, f3, 1'b0);
        logic [31:0] exp = bad ? 32'd0 : model_load(a, f3);
        @(negedge clk);
        rd = 1'b1; wr = 1'b0; addr = a[ADDR_W-1:0]; funct3 = f3;
        #1;
        checks++;
        if (stall !== 1'b1 || rd_valid !== 1'b0 || access_err !== 1'b0) begin
            errors++;
            $display("FAIL read_accept addr=%h: stall=%b rd_valid=%b err=%b, expected stall=1 rd_valid=0 err=0",
                     a, stall, rd_valid, access_err);
        end
        for (int c = 1; c <= READ_LAT; c++) begin
            @(negedge clk);
            // Garbage on every input while waiting; it must all be ignored.
            wr = 1'($urandom_range(0, 1)); rd = 1'($urandom_range(0, 1));
            addr = ADDR_W'($urandom); funct3 = 3'($urandom); wr_data = $urandom;
            #1;
            checks++;
            if (c < READ_LAT) begin
                if (stall !== 1'b1 || rd_valid !== 1'b0 || access_err !== 1'b0) begin
                    errors++;
                    $display("FAIL read_wait addr=%h cyc=%0d: stall=%b rd_valid=%b err=%b, expected 1/0/0",
                             a, c, stall, rd_valid, access_err);
                end
            end else begin
                if (stall !== 1'b0 || rd_valid !== 1'b1 || access_err !== bad ||
                    (chk_data && rd_data !== exp)) begin
                    errors++;
                    $display("FAIL read_done addr=%h f3=%b: stall=%b rd_valid=%b err=%b data=%h, expected 0/1/%b data=%h",
                             a, f3, stall, rd_valid, access_err, rd_data, bad, exp);
                end
            end
        end
        @(posedge clk);
        exp_rd_cnt++;
        if (bad) exp_err_cnt++;
        if (chk_data) last_rd = exp;
        $display("RD   addr=%h f3=%b exp=%h err=%b", a, f3, exp, bad);
    endtask

    task automatic test_reset();
        reset = 1'b0; wr = 1'b0; rd = 1'b1; addr = 9'h010; funct3 = 3'b010;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (rd_data !== 32'd0 || rd_valid !== 1'b0 || stall !== 1'b0 || access_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: rd_data=%h rd_valid=%b stall=%b err=%b, expected all zero",
                     rd_data, rd_valid, stall, access_err);
        end
`ifdef DMEM_STATS_EN
        checks++;
        if (rd_count !== 16'd0 || wr_count !== 16'd0 || err_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_counts: %0d/%0d/%0d, expected 0/0/0", rd_count, wr_count, err_count);
        end
`endif
        @(negedge clk);
        rd = 1'b0; reset = 1'b1;
        $display("RST  released");
    endtask

    task automatic test_first_read();
        do_read(32'h10, 3'b010, 1'b0);
    endtask

    task automatic test_fill();
        for (int w = 0; w < DEPTH / 4; w++) begin
            do_write(w * 4, 3'b010, $urandom);
        end
    endtask

    task automatic test_sub_word();
        do_write(32'h20, 3'b010, 32'hDEAD_BEEF);
        do_read(32'h20, 3'b010, 1'b1);
        do_read(32'h21, 3'b100, 1'b1);
        do_read(32'h23, 3'b000, 1'b1);
        do_write(32'h22, 3'b001, 32'h0000_8001);
        do_read(32'h20, 3'b010, 1'b1);
        do_read(32'h22, 3'b001, 1'b1);
        do_read(32'h22, 3'b101, 1'b1);
        checks++;
        if (model_load(32'h20, 3'b010) !== 32'h8001_BEEF) begin
            errors++;
            $display("FAIL model_word got=%h, required=8001beef", model_load(32'h20, 3'b010));
        end
    endtask

    task automatic test_misaligned();
        do_read(32'h21, 3'b010, 1'b1);
        do_write(32'h22, 3'b010, 32'h1234_5678);
        do_write(32'h21, 3'b001, 32'h0000_5555);
        do_write(32'h20, 3'b100, 32'h0000_00AA);
        do_read(32'h20, 3'b010, 1'b1);
    endtask

    task automatic test_conflict();
        @(negedge clk);
        wr = 1'b1; rd = 1'b1; addr = 9'h020; funct3 = 3'b010; wr_data = 32'h0BAD_0BAD;
        #1;
        checks++;
        if (access_err !== 1'b1 || stall !== 1'b0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL conflict: err=%b stall=%b rd_valid=%b, expected 1/0/0", access_err, stall, rd_valid);
        end
        @(posedge clk);
        exp_err_cnt++;
        $display("WRRD addr=020 conflict");
        @(negedge clk);
        wr = 1'b0; rd = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0 || rd_valid !== 1'b0 || access_err !== 1'b0) begin
            errors++;
            $display("FAIL conflict_after: stall=%b rd_valid=%b err=%b, expected 0/0/0", stall, rd_valid, access_err);
        end
        do_read(32'h20, 3'b010, 1'b1);
        do_read(32'h24, 3'b011, 1'b1);
    endtask

    task automatic test_hold();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            wr = 1'b0; rd = 1'b0; addr = ADDR_W'($urandom); funct3 = 3'($urandom);
            #1;
            checks++;
            if (rd_data !== last_rd || rd_valid !== 1'b0) begin
                errors++;
                $display("FAIL hold: rd_data=%h rd_valid=%b, expected %h/0", rd_data, rd_valid, last_rd);
            end
        end
        $display("HOLD rd_data=%h", last_rd);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            do_read(32'h40 + 4 * i, 3'b010, 1'b1);
        end
        test_hold();
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        rd = 1'b1; wr = 1'b0; addr = 9'h040; funct3 = 3'b010;
        @(posedge clk);
        @(negedge clk);
        rd = 1'b0; reset = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 32'd0 || access_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_read: stall=%b rd_valid=%b data=%h err=%b, expected all zero",
                     stall, rd_valid, rd_data, access_err);
        end
        exp_rd_cnt = 0; exp_wr_cnt = 0; exp_err_cnt = 0; last_rd = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < READ_LAT + 2; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (rd_valid !== 1'b0 || stall !== 1'b0) begin
                errors++;
                $display("FAIL dropped_read cyc=%0d: rd_valid=%b stall=%b, expected 0/0", i, rd_valid, stall);
            end
        end
        $display("RST  mid-read, pending read dropped");
    endtask

    task automatic test_stats();
        do_read(32'h20, 3'b010, 1'b1);
        do_read(32'h44, 3'b000, 1'b1);
        do_read(32'h48, 3'b101, 1'b1);
        do_write(32'h60, 3'b010, 32'hCAFE_F00D);
        do_write(32'h62, 3'b000, 32'h0000_0077);
        do_write(32'h63, 3'b001, 32'h0000_1111);
`ifdef DMEM_STATS_EN
        @(negedge clk);
        wr = 1'b0; rd = 1'b0;
        #1;
        checks++;
        if (rd_count !== 16'd3 || wr_count !== 16'd2 || err_count !== 16'd1) begin
            errors++;
            $display("FAIL stats_counts: %0d/%0d/%0d, expected 3/2/1", rd_count, wr_count, err_count);
        end
`endif
        $display("STAT model rd=%0d wr=%0d err=%0d", exp_rd_cnt, exp_wr_cnt, exp_err_cnt);
    endtask

    task automatic test_random();
        for (int n = 0; n < 150; n++) begin
            int          a  = $urandom_range(0, DEPTH - 1);
            logic [2:0]  f3 = 3'($urandom);
            if ($urandom_range(0, 3) != 0) a = a & ~(acc_size(f3) - 1);
            if ($urandom_range(0, 1) == 0) do_write(a, f3, $urandom);
            else                           do_read(a, f3, 1'b1);
        end
`ifdef DMEM_STATS_EN
        @(negedge clk);
        wr = 1'b0; rd = 1'b0;
        #1;
        checks++;
        if (int'(rd_count) != exp_rd_cnt || int'(wr_count) != exp_wr_cnt || int'(err_count) != exp_err_cnt) begin
            errors++;
            $display("FAIL stats_random: %0d/%0d/%0d, expected %0d/%0d/%0d",
                     rd_count, wr_count, err_count, exp_rd_cnt, exp_wr_cnt, exp_err_cnt);
        end
`endif
        $display("STAT model rd=%0d wr=%0d err=%0d", exp_rd_cnt, exp_wr_cnt, exp_err_cnt);
    endtask

    initial begin
        test_reset();
        test_first_read();
        test_fill();
        test_sub_word();
        test_misaligned();
        test_conflict();
        test_hold();
        test_back_to_back();
        test_reset_mid_read();
        test_stats();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
